// File: rtl/addsub_pkg.sv
// Shared types for the round-robin add/subtract scheduler.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/addsub_unit.sv
// Combinational two's-complement adder/subtractor with signed-overflow flag.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff      = (sel_i == OP_SUB) ? ~b_i : b_i;
    result_o   = a_i + b_eff + WIDTH'(sel_i);
    overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin arbiter sharing one adder/subtractor between NREQ requesters,
// with a one-entry registered response slot and a saturating overflow counter.
module addsub_rr_scheduler
  import addsub_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  input  logic [NREQ-1:0]           req_sel,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_result,
  output logic                      rsp_overflow,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  input  logic                      ovf_clr,
  output logic [CNTW-1:0]           ovf_count
);

  localparam int unsigned IDW = $clog2(NREQ);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             gnt_valid;
  logic [IDW-1:0]   gnt_idx;
  logic             slot_free;
  logic             grant_fire;
  logic [WIDTH-1:0] op_a, op_b, alu_result;
  op_e              op_sel;
  logic             alu_ovf;
  int               idx;

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(NREQ);
      if (!gnt_valid && req_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    slot_free  = (state_q == EMPTY) || rsp_ready;
    grant_fire = slot_free && gnt_valid && !rst;
    req_ready  = grant_fire ? (NREQ'(1) << gnt_idx) : '0;
    op_a       = req_a[int'(gnt_idx)*int'(WIDTH) +: WIDTH];
    op_b       = req_b[int'(gnt_idx)*int'(WIDTH) +: WIDTH];
    op_sel     = op_e'(req_sel[gnt_idx]);
  end

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a_i        (op_a),
    .b_i        (op_b),
    .sel_i      (op_sel),
    .result_o   (alu_result),
    .overflow_o (alu_ovf)
  );

  // Next-state: response slot, pointer and overflow counter.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    id_d     = id_q;
    cnt_d    = cnt_q;

    case (state_q)
      EMPTY: if (grant_fire) state_d = FULL;
      FULL:  if (rsp_ready && !grant_fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (grant_fire) begin
      result_d = alu_result;
      ovf_d    = alu_ovf;
      id_d     = gnt_idx;
      rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end

    if (ovf_clr) begin
      cnt_d = '0;
    end else if ((state_q == FULL) && rsp_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_result   = result_q;
  assign rsp_overflow = ovf_q;
  assign rsp_id       = id_q;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench: vector table, directed corner sequences and random traffic
// against a transaction-level model of the scheduler.
module tb_addsub_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_result;
  logic        rsp_overflow;
  logic [1:0]  rsp_id;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  logic [3:0] va [4];
  logic [3:0] vb [4];

  int tests;
  int fails;

  // model state
  bit m_full;
  int m_res;
  bit m_ovf;
  int m_id;
  int m_ptr;
  int m_cnt;

  addsub_rr_scheduler #(.NREQ(4), .WIDTH(4), .CNTW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id),
    .ovf_clr      (ovf_clr),
    .ovf_count    (ovf_count)
  );

  always_comb begin
    req_a = {va[3], va[2], va[1], va[0]};
    req_b = {vb[3], vb[2], vb[1], vb[0]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed4(input logic [3:0] v);
    return (v >= 8) ? int'(v) - 16 : int'(v);
  endfunction

  // Signed-integer arithmetic reference: overflow means out of the 4-bit signed range.
  task automatic model_op(input logic [3:0] a, input logic [3:0] b, input bit sub,
                          output int res, output bit ovf);
    int r;
    r   = sub ? to_signed4(a) - to_signed4(b) : to_signed4(a) + to_signed4(b);
    ovf = (r > 7) || (r < -8);
    res = r & 15;
  endtask

  function automatic int model_grant();
    if (rst || (m_full && !rsp_ready)) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_res = 0; m_ovf = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_update(input int g);
    int r;
    bit o;
    if (ovf_clr) m_cnt = 0;
    else if (m_full && rsp_ready && m_ovf && m_cnt < 255) m_cnt++;
    if (g >= 0) begin
      model_op(va[g], vb[g], req_sel[g], r, o);
      m_res = r; m_ovf = o; m_id = g; m_full = 1; m_ptr = (g + 1) % 4;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " rsp_valid"},    32'(rsp_valid),    32'(m_full));
    check({tag, " rsp_result"},   32'(rsp_result),   32'(m_res));
    check({tag, " rsp_overflow"}, 32'(rsp_overflow), 32'(m_ovf));
    check({tag, " rsp_id"},       32'(rsp_id),       32'(m_id));
    check({tag, " ovf_count"},    32'(ovf_count),    32'(m_cnt));
  endtask

  // One clock: inputs already applied; check grant, clock, check registered outputs.
  task automatic step(input string tag);
    int g;
    logic [3:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    model_update(g);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input bit sub);
    va[i] = a; vb[i] = b; req_sel[i] = sub;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset req_ready", 32'(req_ready), 32'h0);
    check_outputs("reset");
    @(posedge clk);
    #1;
    check_outputs("reset held");
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         sub;
    logic [3:0] exp_res;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs [8];
  logic [3:0] hold_res;
  logic [1:0] hold_id;
  logic       hold_ovf;
  int         exp_ids [6];
  int         exp_seq [3];

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; req_valid = '0; req_sel = '0; rsp_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin va[i] = '0; vb[i] = '0; end
    model_reset();

    vecs[0] = '{4'd3, 4'd4, 1'b0, 4'd7, 1'b0};
    vecs[1] = '{4'd7, 4'hF, 1'b1, 4'h8, 1'b1};
    vecs[2] = '{4'h8, 4'd1, 1'b1, 4'h7, 1'b1};
    vecs[3] = '{4'd5, 4'd4, 1'b0, 4'h9, 1'b1};
    vecs[4] = '{4'hF, 4'h8, 1'b1, 4'd7, 1'b0};
    vecs[5] = '{4'hF, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{4'h8, 4'h8, 1'b0, 4'd0, 1'b1};
    vecs[7] = '{4'd2, 4'd3, 1'b1, 4'hF, 1'b0};

    @(posedge clk);
    do_reset();

    // Vector table through requester 0.
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req_valid = 4'b0001;
      set_req(0, vecs[v].a, vecs[v].b, vecs[v].sub);
      step("vec");
      check($sformatf("vec%0d result", v), 32'(rsp_result), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d ovf", v), 32'(rsp_overflow), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d id", v), 32'(rsp_id), 32'd0);
      check($sformatf("vec%0d valid", v), 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    step("drain");

    // All requesters valid: ids rotate 0,1,2,3,0,1.
    do_reset();
    exp_ids = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 4'd1, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step("rr all");
      check($sformatf("rr all id%0d", c), 32'(rsp_id), 32'(exp_ids[c]));
    end

    // req1 only, then req0 and req2: order 1,2,0.
    req_valid = '0;
    do_reset();
    exp_seq = '{1, 2, 0};
    req_valid = 4'b0010;
    step("rr seq");
    check("rr seq id0", 32'(rsp_id), 32'(exp_seq[0]));
    req_valid = 4'b0101;
    step("rr seq");
    check("rr seq id1", 32'(rsp_id), 32'(exp_seq[1]));
    req_valid = 4'b0001;
    step("rr seq");
    check("rr seq id2", 32'(rsp_id), 32'(exp_seq[2]));
    req_valid = '0;
    step("rr seq drain");

    // Backpressure: FULL with rsp_ready low holds everything.
    do_reset();
    set_req(0, 4'd6, 4'd1, 1'b0);
    set_req(1, 4'd2, 4'd5, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step("bp fill");
    req_valid = 4'b0010;
    hold_res = rsp_result; hold_id = rsp_id; hold_ovf = rsp_overflow;
    for (int c = 0; c < 3; c++) begin
      step("bp hold");
      check("bp stable result", 32'(rsp_result), 32'(hold_res));
      check("bp stable id", 32'(rsp_id), 32'(hold_id));
      check("bp stable ovf", 32'(rsp_overflow), 32'(hold_ovf));
      check("bp stable valid", 32'(rsp_valid), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release grant", 32'(req_ready), 32'b0010);
    step("bp release");
    check("bp release id", 32'(rsp_id), 32'd1);
    check("bp release result", 32'(rsp_result), 32'hD);
    req_valid = '0;

    // Reset mid-stream with a response held.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_req(2, 4'd5, 4'd4, 1'b0);
    step("mid fill");
    req_valid = 4'b1111;
    do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("post reset");
      check("post reset valid", 32'(rsp_valid), 32'd0);
    end

    // Overflow counter saturation, then clear racing an overflow accept.
    set_req(0, 4'd5, 4'd4, 1'b0);
    req_valid = 4'b0001;
    for (int c = 0; c < 260; c++) step("sat");
    check("sat count", 32'(ovf_count), 32'd255);
    ovf_clr = 1'b1;
    step("clr");
    check("clr count", 32'(ovf_count), 32'd0);
    ovf_clr = 1'b0;
    step("after clr");
    check("after clr count", 32'(ovf_count), 32'd1);

    // Random traffic; operands only change while idle or just granted.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] granted;
      granted = req_ready;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || granted[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, 4'($urandom), 4'($urandom), 1'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound the run.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
